// File: rtl/rename_regfile_mw.sv
// Multi-issue architectural register file with rename/busy table and intra-bundle forwarding.
// Define REGFILE_COMMIT_BYPASS_EN to forward same-cycle tag-matching commits into lookups.
module rename_regfile_mw #(
  parameter int XLEN     = 32,
  parameter int REG_NUM  = 32,
  parameter int ROB_W    = 4,
  parameter int ISSUE_W  = 2,
  parameter int COMMIT_W = 2,
  localparam int RIDX_W  = $clog2(REG_NUM)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic [ISSUE_W-1:0]           issue_valid,
  input  logic [ISSUE_W*RIDX_W-1:0]    issue_rs1,
  input  logic [ISSUE_W*RIDX_W-1:0]    issue_rs2,
  input  logic [ISSUE_W*RIDX_W-1:0]    issue_rd,
  input  logic [ISSUE_W-1:0]           rename_valid,
  input  logic [ISSUE_W*ROB_W-1:0]     rename_tag,
  output logic [ISSUE_W*ROB_W-1:0]     issue_Qj,
  output logic [ISSUE_W*ROB_W-1:0]     issue_Qk,
  output logic [ISSUE_W*XLEN-1:0]      issue_Vj,
  output logic [ISSUE_W*XLEN-1:0]      issue_Vk,
  output logic [ISSUE_W-1:0]           issue_Rj,
  output logic [ISSUE_W-1:0]           issue_Rk,
  input  logic [COMMIT_W-1:0]          commit_valid,
  input  logic [COMMIT_W*RIDX_W-1:0]   commit_rd,
  input  logic [COMMIT_W*ROB_W-1:0]    commit_tag,
  input  logic [COMMIT_W*XLEN-1:0]     commit_val,
  input  logic                         rollback,
  output logic [RIDX_W:0]              busy_count
);

  typedef struct packed {
    logic             r;
    logic [ROB_W-1:0] q;
    logic [XLEN-1:0]  v;
  } opnd_t;

  logic [XLEN-1:0]    val_q   [REG_NUM];
  logic [ROB_W-1:0]   tag_q   [REG_NUM];
  logic [REG_NUM-1:0] busy_q;
  logic [XLEN-1:0]    val_nxt [REG_NUM];
  logic [ROB_W-1:0]   tag_nxt [REG_NUM];
  logic [REG_NUM-1:0] busy_nxt;

  // Later loop iterations overwrite earlier ones, so the youngest matching producer wins.
  function automatic opnd_t lookup(input int k, input logic [RIDX_W-1:0] s);
    opnd_t o;
    logic  hit;
    o   = '0;
    hit = 1'b0;
    if (issue_valid[k]) begin
      if (s == '0) begin
        o.r = 1'b1;
      end else begin
        for (int j = 0; j < k; j++) begin
          if (rename_valid[j] && issue_rd[j*RIDX_W +: RIDX_W] == s) begin
            hit = 1'b1;
            o.q = rename_tag[j*ROB_W +: ROB_W];
          end
        end
`ifdef REGFILE_COMMIT_BYPASS_EN
        if (!hit && !rollback && busy_q[s]) begin
          for (int p = 0; p < COMMIT_W; p++) begin
            if (commit_valid[p] && commit_rd[p*RIDX_W +: RIDX_W] == s &&
                commit_tag[p*ROB_W +: ROB_W] == tag_q[s]) begin
              hit = 1'b1;
              o.r = 1'b1;
              o.v = commit_val[p*XLEN +: XLEN];
            end
          end
        end
`endif
        if (!hit) begin
          if (busy_q[s]) begin
            o.q = tag_q[s];
          end else begin
            o.r = 1'b1;
            o.v = val_q[s];
          end
        end
      end
    end
    return o;
  endfunction

  always_comb begin
    opnd_t a, b;
    a = '0;
    b = '0;
    issue_Qj = '0;
    issue_Qk = '0;
    issue_Vj = '0;
    issue_Vk = '0;
    issue_Rj = '0;
    issue_Rk = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      a = lookup(k, issue_rs1[k*RIDX_W +: RIDX_W]);
      b = lookup(k, issue_rs2[k*RIDX_W +: RIDX_W]);
      issue_Rj[k] = a.r;
      issue_Rk[k] = b.r;
      issue_Qj[k*ROB_W +: ROB_W] = a.q;
      issue_Qk[k*ROB_W +: ROB_W] = b.q;
      issue_Vj[k*XLEN +: XLEN]   = a.v;
      issue_Vk[k*XLEN +: XLEN]   = b.v;
    end
  end

  // Commit clears test pre-cycle busy/tag; renames are applied last so they override clears.
  always_comb begin
    logic [RIDX_W-1:0] rd;
    rd       = '0;
    val_nxt  = val_q;
    tag_nxt  = tag_q;
    busy_nxt = busy_q;
    if (rollback) begin
      busy_nxt = '0;
      for (int i = 0; i < REG_NUM; i++) tag_nxt[i] = '0;
    end else begin
      for (int p = 0; p < COMMIT_W; p++) begin
        rd = commit_rd[p*RIDX_W +: RIDX_W];
        if (commit_valid[p] && rd != '0) begin
          val_nxt[rd] = commit_val[p*XLEN +: XLEN];
          if (busy_q[rd] && tag_q[rd] == commit_tag[p*ROB_W +: ROB_W]) busy_nxt[rd] = 1'b0;
        end
      end
      for (int k = 0; k < ISSUE_W; k++) begin
        rd = issue_rd[k*RIDX_W +: RIDX_W];
        if (rename_valid[k] && rd != '0) begin
          tag_nxt[rd]  = rename_tag[k*ROB_W +: ROB_W];
          busy_nxt[rd] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_count <= '0;
    end else if (rdy) begin
      val_q      <= val_nxt;
      tag_q      <= tag_nxt;
      busy_q     <= busy_nxt;
      busy_count <= (RIDX_W+1)'($countones(busy_nxt));
    end
  end

endmodule
